// File: rtl/poly_decompress.sv
// Unpacks a little-endian stream of D-bit compressed coefficients and decompresses
// each to round(x*3329/2^D), emitting even-indexed pairs. Optional: POLY_DECOMPRESS_RAW_EN.
module poly_decompress #(
    parameter int D    = 10,
    parameter int N    = 256,
    parameter int BUFW = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        start,
    input  logic        readin,
    input  logic        full_in,
    input  logic [7:0]  din,
`ifdef POLY_DECOMPRESS_RAW_EN
    input  logic        raw_mode,
`endif
    output logic        readin_ok,
    output logic [15:0] dout_1,
    output logic [15:0] dout_2,
    output logic [7:0]  out_index,
    output logic        readout,
    output logic        done,
    output logic        err
);

    localparam int NBYTES = N * D / 8;
    localparam int PAIRS  = N / 2;
    localparam int CW     = $clog2(BUFW + 1);
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int PCW    = $clog2(PAIRS + 1);
    localparam int PW     = D + 12;
    localparam logic [PW-1:0] Q     = PW'(3329);
    localparam logic [PW-1:0] ROUND = PW'(1) << (D - 1);

    // Handshake: a byte on din is consumed at a rising edge exactly when
    // readin & readin_ok & set are all high; readout is a one-cycle valid with
    // no backpressure, and like every register it holds while set is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [BUFW-1:0] bit_buf;
    logic [CW-1:0]   bit_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic [PCW-1:0]  pair_cnt;
`ifdef POLY_DECOMPRESS_RAW_EN
    logic            raw_q;
`endif

    logic            accept;
    logic            extract;
    logic            last_byte;
    logic [BUFW-1:0] buf_shift;
    logic [BUFW-1:0] buf_next;
    logic [CW-1:0]   pos;
    logic [CW-1:0]   cnt_next;
    logic [D-1:0]    x0;
    logic [D-1:0]    x1;
    logic [15:0]     c0;
    logic [15:0]     c1;

    function automatic logic [15:0] decomp(input logic [D-1:0] x);
        logic [PW-1:0] prod;
        prod   = (PW'(x) * Q) + ROUND;
        decomp = 16'(prod >> D);
    endfunction

    assign readin_ok = (state == S_RUN) && (bit_cnt <= CW'(BUFW - 8));
    assign accept    = readin && readin_ok && set;
    assign extract   = ((state == S_RUN) || (state == S_DRAIN)) &&
                       (bit_cnt >= CW'(2 * D)) && (pair_cnt < PCW'(PAIRS));
    assign last_byte = (byte_cnt == BCW'(NBYTES - 1));
    assign x0        = bit_buf[D-1:0];
    assign x1        = bit_buf[2*D-1:D];

    // A byte accepted in an extraction cycle lands just above the bits that remain.
    always_comb begin
        buf_shift = extract ? (bit_buf >> (2 * D)) : bit_buf;
        pos       = extract ? (bit_cnt - CW'(2 * D)) : bit_cnt;
        buf_next  = buf_shift;
        cnt_next  = pos;
        if (accept) begin
            buf_next = buf_shift | (BUFW'(din) << pos);
            cnt_next = pos + CW'(8);
        end
    end

    always_comb begin
        c0 = decomp(x0);
        c1 = decomp(x1);
`ifdef POLY_DECOMPRESS_RAW_EN
        if (raw_q) begin
            c0 = 16'(x0);
            c1 = 16'(x1);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_buf   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            pair_cnt  <= '0;
            dout_1    <= '0;
            dout_2    <= '0;
            out_index <= '0;
            readout   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef POLY_DECOMPRESS_RAW_EN
            raw_q     <= 1'b0;
`endif
        end else if (set) begin
            readout <= 1'b0;
            bit_buf <= buf_next;
            bit_cnt <= cnt_next;
            if (accept) begin
                byte_cnt <= byte_cnt + BCW'(1);
            end
            if (extract) begin
                dout_1    <= c0;
                dout_2    <= c1;
                out_index <= 8'({pair_cnt, 1'b0});
                readout   <= 1'b1;
                pair_cnt  <= pair_cnt + PCW'(1);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RUN;
                        bit_buf  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        pair_cnt <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
`ifdef POLY_DECOMPRESS_RAW_EN
                        raw_q    <= raw_mode;
`endif
                    end
                end
                S_RUN: begin
                    if (accept && (last_byte || full_in)) begin
                        state <= S_DRAIN;
                        if (full_in && !last_byte) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Nothing left to extract: either all pairs are out or the
                    // leftover bits after an early full_in cannot form a pair.
                    if (!extract) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
